// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg
//   Shared encodings for the MEM-stage access unit: load funct3 codes, store
//   size codes, the 2-bit MAU state codes and the internal access-size type.
//   It also holds small helpers that classify an access by size and by
//   alignment.
package mem_access_unit_pkg;

  // Load funct3 codes (mem_read[2:0])
  localparam logic [2:0] LOAD_LB  = 3'b000;
  localparam logic [2:0] LOAD_LH  = 3'b001;
  localparam logic [2:0] LOAD_LW  = 3'b010;
  localparam logic [2:0] LOAD_LBU = 3'b100;
  localparam logic [2:0] LOAD_LHU = 3'b101;

  // Store size codes (mem_write[1:0])
  localparam logic [1:0] STORE_BYTE = 2'b00;
  localparam logic [1:0] STORE_HALF = 2'b01;
  localparam logic [1:0] STORE_WORD = 2'b10;

  // MAU state codes
  localparam logic [1:0] MAU_IDLE = 2'd0;
  localparam logic [1:0] MAU_BUSY = 2'd1;
  localparam logic [1:0] MAU_DONE = 2'd2;
  localparam logic [1:0] MAU_ERR  = 2'd3;

  typedef enum logic [1:0] {
    SIZE_BYTE,
    SIZE_HALF,
    SIZE_WORD
  } access_size_t;

  // Undefined load codes behave as LW, so they fall into the word case.
  function automatic access_size_t load_size(input logic [2:0] funct3);
    case (funct3)
      LOAD_LB, LOAD_LBU: return SIZE_BYTE;
      LOAD_LH, LOAD_LHU: return SIZE_HALF;
      default:           return SIZE_WORD;
    endcase
  endfunction

  // The reserved store code 2'b11 is handled as a word store.
  function automatic access_size_t store_size(input logic [1:0] code);
    case (code)
      STORE_BYTE: return SIZE_BYTE;
      STORE_HALF: return SIZE_HALF;
      default:    return SIZE_WORD;
    endcase
  endfunction

  function automatic logic is_misaligned(input access_size_t size, input logic [1:0] addr_lo);
    case (size)
      SIZE_HALF: return addr_lo[0];
      SIZE_WORD: return |addr_lo;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_load_formatter.sv
// load_formatter
//   Combinational load-data formatting. It selects the addressed byte or
//   halfword from the fetched word, then sign- or zero-extends it according
//   to funct3.
// Ports
//   rdata     in  32  word read from data memory
//   addr_lo   in  2   byte offset of the access within the word
//   funct3    in  3   load type (LB/LH/LW/LBU/LHU, others treated as LW)
//   load_data out 32  formatted write-back value
module load_formatter
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] load_data
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;

  // Lane selection and extension. Only the lanes that are actually addressed
  // are extracted, so every bit of rdata has a consumer.
  always_comb begin
    byte_val = rdata[7:0];
    case (addr_lo)
      2'd1:    byte_val = rdata[15:8];
      2'd2:    byte_val = rdata[23:16];
      2'd3:    byte_val = rdata[31:24];
      default: byte_val = rdata[7:0];
    endcase
    half_val = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    case (funct3)
      LOAD_LB:  load_data = {{24{byte_val[7]}}, byte_val};
      LOAD_LBU: load_data = {24'h0, byte_val};
      LOAD_LH:  load_data = {{16{half_val[15]}}, half_val};
      LOAD_LHU: load_data = {16'h0, half_val};
      default:  load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit
//   MEM-stage data-memory access unit. It turns the EX/MEM load/store request
//   into a req/ack bus transaction that carries byte enables and store data
//   shifted to the correct lanes. It also formats the returned load data and
//   stalls the pipeline until the access completes or faults. A fault is
//   either a misaligned access or a bus timeout.
// Ports
//   clk, rst         clock (rising edge), asynchronous active-high reset
//   alu_result       effective byte address
//   store_data       rs2 value to store
//   mem_read         [3] load enable, [2:0] funct3
//   mem_write        [2] store enable, [1:0] size
//   dmem_req/we      bus request (held until ack) and write flag
//   dmem_addr        word-aligned bus address
//   dmem_wdata/be    lane-shifted store data and byte enables
//   dmem_rdata/ack   read word and one-cycle completion strobe
//   load_data        formatted load result, valid in DONE
//   mem_stall        freezes IF..EX/MEM while high
//   mem_fault        one-cycle pulse on misalignment or timeout
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic [3:0]  mem_read,
  input  logic [2:0]  mem_write,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic [31:0] load_data,
  output logic        mem_stall,
  output logic        mem_fault
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [1:0]   state;
  logic [7:0]   cnt;
  logic [31:0]  rdata_q;
  logic [1:0]   addr_lo_q;
  logic [2:0]   funct3_q;
  logic         is_load_q;

  logic         is_store;
  logic         access;
  access_size_t size;
  logic         misaligned;
  logic [31:0]  lane_wdata;
  logic [3:0]   lane_be;
  logic [31:0]  fmt_data;

  // Classify the incoming request. A store takes priority when both enables
  // are set. The lane data and byte enables computed here are registered only
  // on the IDLE->BUSY transition.
  always_comb begin
    is_store   = mem_write[2];
    access     = mem_read[3] | is_store;
    size       = is_store ? store_size(mem_write[1:0]) : load_size(mem_read[2:0]);
    misaligned = is_misaligned(size, alu_result[1:0]);

    lane_wdata = store_data;
    lane_be    = 4'b1111;
    case (size)
      SIZE_BYTE: begin
        lane_wdata = {4{store_data[7:0]}};
        lane_be    = 4'b0001 << alu_result[1:0];
      end
      SIZE_HALF: begin
        lane_wdata = {2{store_data[15:0]}};
        lane_be    = alu_result[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        lane_wdata = store_data;
        lane_be    = 4'b1111;
      end
    endcase
  end

  // Transaction FSM with bus-side registers. The timeout counter counts BUSY
  // cycles without an ack. The load offset and funct3 are captured at the
  // start of the access, so later EX/MEM changes cannot disturb formatting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= MAU_IDLE;
      cnt        <= 8'd0;
      rdata_q    <= 32'd0;
      addr_lo_q  <= 2'd0;
      funct3_q   <= 3'd0;
      is_load_q  <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= 32'd0;
      dmem_wdata <= 32'd0;
      dmem_be    <= 4'd0;
    end else begin
      case (state)
        MAU_IDLE: begin
          if (access) begin
            if (misaligned) begin
              state <= MAU_ERR;
            end else begin
              state      <= MAU_BUSY;
              dmem_req   <= 1'b1;
              dmem_we    <= is_store;
              dmem_addr  <= {alu_result[31:2], 2'b00};
              dmem_wdata <= is_store ? lane_wdata : 32'd0;
              dmem_be    <= is_store ? lane_be : 4'b1111;
              cnt        <= 8'd0;
              addr_lo_q  <= alu_result[1:0];
              funct3_q   <= mem_read[2:0];
              is_load_q  <= ~is_store;
            end
          end
        end
        MAU_BUSY: begin
          if (dmem_ack) begin
            rdata_q  <= dmem_rdata;
            dmem_req <= 1'b0;
            state    <= MAU_DONE;
          end else if (cnt == CNT_LAST) begin
            dmem_req <= 1'b0;
            state    <= MAU_ERR;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= MAU_IDLE;
      endcase
    end
  end

  load_formatter u_load_formatter (
    .rdata     (rdata_q),
    .addr_lo   (addr_lo_q),
    .funct3    (funct3_q),
    .load_data (fmt_data)
  );

  // The stall is released in DONE and ERR, so the pipeline advances at the
  // edge that closes the access. It is also forced low while reset is held.
  assign mem_stall = ~rst & (((state == MAU_IDLE) & access) | (state == MAU_BUSY));
  assign mem_fault = (state == MAU_ERR);
  assign load_data = ((state == MAU_DONE) && is_load_q) ? fmt_data : 32'd0;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit
//   Directed bench for mem_access_unit with TIMEOUT_CYCLES=4. A transaction
//   model derives the expected per-cycle outputs from address arithmetic and
//   the access timeline. A single negedge compare process checks the DUT
//   against that model, plus literal pins for the hand-worked cases.
module tb_mem_access_unit;

  localparam int TMO = 4;

  logic        clk;
  logic        rst;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic [3:0]  mem_read;
  logic [2:0]  mem_write;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic [31:0] load_data;
  logic        mem_stall;
  logic        mem_fault;

  mem_access_unit #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .alu_result (alu_result),
    .store_data (store_data),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_be    (dmem_be),
    .dmem_rdata (dmem_rdata),
    .dmem_ack   (dmem_ack),
    .load_data  (load_data),
    .mem_stall  (mem_stall),
    .mem_fault  (mem_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected per-cycle outputs, written by the stimulus process
  logic        exp_req, exp_stall, exp_fault, exp_we;
  logic [31:0] exp_load, exp_addr, exp_wdata;
  logic [3:0]  exp_be;
  bit          chk_en, chk_bus, chk_wdata;
  bit          pin_bus, pin_wd, pin_ld;
  logic [31:0] pin_addr_v, pin_wdata_v, pin_load_v;
  logic [3:0]  pin_be_v;
  int          n_checks = 0;
  int          n_fail   = 0;

  // Transaction model
  function automatic int model_nbytes(input bit st, input logic [2:0] code);
    if (st) return (code[1:0] == 2'b00) ? 1 : (code[1:0] == 2'b01) ? 2 : 4;
    if (code == 3'b000 || code == 3'b100) return 1;
    if (code == 3'b001 || code == 3'b101) return 2;
    return 4;
  endfunction

  function automatic logic [3:0] model_be(input bit st, input int nb, input logic [31:0] addr);
    int idx;
    idx = int'(addr % 4);
    if (!st || nb == 4) return 4'hF;
    if (nb == 1) return 4'(1 << idx);
    return (idx >= 2) ? 4'hC : 4'h3;
  endfunction

  function automatic logic [31:0] model_wdata(input int nb, input logic [31:0] data);
    if (nb == 1) return (data & 32'hFF) * 32'h0101_0101;
    if (nb == 2) return (data & 32'hFFFF) * 32'h0001_0001;
    return data;
  endfunction

  function automatic logic [31:0] model_load(input bit st, input logic [2:0] code,
                                             input logic [31:0] addr, input logic [31:0] rdata);
    logic [31:0] v;
    int nb, idx;
    if (st) return 32'd0;
    nb  = model_nbytes(1'b0, code);
    idx = int'(addr % 4);
    if (nb == 1) begin
      v = (rdata >> (8 * idx)) & 32'hFF;
      if (code == 3'b000 && v >= 128) v = v | 32'hFFFF_FF00;
    end else if (nb == 2) begin
      v = (rdata >> (16 * (idx / 2))) & 32'hFFFF;
      if (code == 3'b001 && v >= 32768) v = v | 32'hFFFF_0000;
    end else begin
      v = rdata;
    end
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // The one compare process, sampling half a cycle after the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("dmem_req",  {31'd0, dmem_req},  {31'd0, exp_req});
      checkOutput("mem_stall", {31'd0, mem_stall}, {31'd0, exp_stall});
      checkOutput("mem_fault", {31'd0, mem_fault}, {31'd0, exp_fault});
      checkOutput("load_data", load_data, exp_load);
      if (chk_bus) begin
        checkOutput("dmem_we",   {31'd0, dmem_we}, {31'd0, exp_we});
        checkOutput("dmem_addr", dmem_addr, exp_addr);
        checkOutput("dmem_be",   {28'd0, dmem_be}, {28'd0, exp_be});
      end
      if (chk_wdata) checkOutput("dmem_wdata", dmem_wdata, exp_wdata);
      if (pin_bus) begin
        checkOutput("pin_addr", dmem_addr, pin_addr_v);
        checkOutput("pin_be", {28'd0, dmem_be}, {28'd0, pin_be_v});
      end
      if (pin_wd) checkOutput("pin_wdata", dmem_wdata, pin_wdata_v);
      if (pin_ld) checkOutput("pin_load", load_data, pin_load_v);
    end
  end

  task automatic setExpIdle();
    exp_req = 1'b0; exp_stall = 1'b0; exp_fault = 1'b0; exp_load = 32'd0;
    chk_bus = 1'b0; chk_wdata = 1'b0;
    pin_bus = 1'b0; pin_wd = 1'b0; pin_ld = 1'b0;
  endtask

  task automatic setExpReset();
    setExpIdle();
    chk_bus = 1'b1; chk_wdata = 1'b1;
    exp_we = 1'b0; exp_addr = 32'd0; exp_be = 4'd0; exp_wdata = 32'd0;
  endtask

  task automatic driveIdle();
    mem_read = 4'd0; mem_write = 3'd0; alu_result = 32'd0; store_data = 32'd0;
    dmem_ack = 1'b0; dmem_rdata = 32'd0;
  endtask

  // One complete access. ack_at is the BUSY cycle (1-based) in which the
  // bench acks; 0 means never ack, which forces a timeout. Pins are checked
  // when pin_en is set.
  task automatic applyStimulus(input bit st, input logic [2:0] code, input logic [31:0] addr,
                               input logic [31:0] data, input logic [31:0] rdata, input int ack_at,
                               input bit pin_en, input logic [31:0] p_addr, input logic [3:0] p_be,
                               input logic [31:0] p_wdata, input logic [31:0] p_load);
    int nb;
    bit mis, acked;
    nb    = model_nbytes(st, code);
    mis   = (addr % nb) != 0;
    acked = 1'b0;

    @(posedge clk); #1;
    mem_read   = st ? 4'd0 : {1'b1, code};
    mem_write  = st ? {1'b1, code[1:0]} : 3'd0;
    alu_result = addr;
    store_data = data;
    dmem_ack   = 1'b0;
    setExpIdle();
    exp_stall = 1'b1;

    if (mis) begin
      @(posedge clk); #1;
      driveIdle();
      exp_stall = 1'b0; exp_fault = 1'b1;
      @(posedge clk); #1;
      exp_fault = 1'b0;
      return;
    end

    for (int k = 1; k <= TMO; k++) begin
      @(posedge clk); #1;
      exp_req = 1'b1; exp_stall = 1'b1;
      chk_bus = 1'b1; exp_we = st; exp_addr = addr & 32'hFFFF_FFFC;
      exp_be = model_be(st, nb, addr);
      chk_wdata = st; exp_wdata = model_wdata(nb, data);
      pin_bus = pin_en; pin_wd = pin_en && st;
      pin_addr_v = p_addr; pin_be_v = p_be; pin_wdata_v = p_wdata;
      alu_result = addr ^ 32'h0000_0F0D;
      store_data = data ^ 32'h5A5A_FFFF;
      if (k == ack_at) begin
        dmem_ack = 1'b1; dmem_rdata = rdata; acked = 1'b1;
        break;
      end else begin
        dmem_ack = 1'b0; dmem_rdata = ~rdata;
      end
    end

    @(posedge clk); #1;
    driveIdle();
    setExpIdle();
    if (acked) begin
      exp_load = model_load(st, code, addr, rdata);
      pin_ld = pin_en; pin_load_v = p_load;
    end else begin
      exp_fault = 1'b1;
    end

    @(posedge clk); #1;
    setExpIdle();
    if (!acked) begin
      dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    end
    @(posedge clk); #1;
    dmem_ack = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] simulation did not terminate");
  end

  initial begin
    rst = 1'b1;
    driveIdle();
    setExpReset();
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Word load with two BUSY cycles
    applyStimulus(1'b0, 3'b010, 32'h100, 32'd0, 32'hDEAD_BEEF, 2, 1'b1, 32'h100, 4'hF, 32'd0, 32'hDEAD_BEEF);
    // Byte and half loads with sign and zero extension
    applyStimulus(1'b0, 3'b000, 32'h103, 32'd0, 32'h80FF_0000, 1, 1'b1, 32'h100, 4'hF, 32'd0, 32'hFFFF_FF80);
    applyStimulus(1'b0, 3'b100, 32'h103, 32'd0, 32'h80FF_0000, 1, 1'b1, 32'h100, 4'hF, 32'd0, 32'h0000_0080);
    applyStimulus(1'b0, 3'b001, 32'h102, 32'd0, 32'h80FF_0000, 1, 1'b1, 32'h100, 4'hF, 32'd0, 32'hFFFF_80FF);
    applyStimulus(1'b0, 3'b101, 32'h102, 32'd0, 32'h80FF_0000, 1, 1'b1, 32'h100, 4'hF, 32'd0, 32'h0000_80FF);
    applyStimulus(1'b0, 3'b000, 32'h101, 32'd0, 32'h1234_7F56, 1, 1'b1, 32'h100, 4'hF, 32'd0, 32'h0000_007F);
    // An undefined funct3 behaves as LW
    applyStimulus(1'b0, 3'b011, 32'h108, 32'd0, 32'h1234_5678, 3, 1'b1, 32'h108, 4'hF, 32'd0, 32'h1234_5678);
    // Stores: lane replication and byte enables
    applyStimulus(1'b1, 3'b000, 32'h201, 32'h0000_00AB, 32'd0, 1, 1'b1, 32'h200, 4'b0010, 32'hABAB_ABAB, 32'd0);
    applyStimulus(1'b1, 3'b001, 32'h202, 32'h0000_1234, 32'd0, 2, 1'b1, 32'h200, 4'b1100, 32'h1234_1234, 32'd0);
    applyStimulus(1'b1, 3'b001, 32'h204, 32'hFFFF_9876, 32'd0, 1, 1'b1, 32'h204, 4'b0011, 32'h9876_9876, 32'd0);
    applyStimulus(1'b1, 3'b010, 32'h208, 32'hCAFE_F00D, 32'd0, 3, 1'b1, 32'h208, 4'b1111, 32'hCAFE_F00D, 32'd0);
    // Misaligned accesses fault without a bus request
    applyStimulus(1'b0, 3'b010, 32'h102, 32'd0, 32'd0, 1, 1'b0, 32'd0, 4'd0, 32'd0, 32'd0);
    applyStimulus(1'b1, 3'b001, 32'h201, 32'h1234, 32'd0, 1, 1'b0, 32'd0, 4'd0, 32'd0, 32'd0);
    applyStimulus(1'b0, 3'b101, 32'h10F, 32'd0, 32'd0, 1, 1'b0, 32'd0, 4'd0, 32'd0, 32'd0);
    // Bus timeout followed by a late ack
    applyStimulus(1'b0, 3'b010, 32'h400, 32'd0, 32'h1111_2222, 0, 1'b0, 32'd0, 4'd0, 32'd0, 32'd0);
    // Ack on the last allowed BUSY cycle still completes normally
    applyStimulus(1'b0, 3'b010, 32'h40C, 32'd0, 32'hA5A5_0F0F, TMO, 1'b1, 32'h40C, 4'hF, 32'd0, 32'hA5A5_0F0F);

    // Reset asserted while BUSY, followed by a stray ack
    @(posedge clk); #1;
    mem_read = 4'b1010; alu_result = 32'h300;
    setExpIdle(); exp_stall = 1'b1;
    @(posedge clk); #1;
    exp_req = 1'b1; chk_bus = 1'b1; exp_we = 1'b0; exp_addr = 32'h300; exp_be = 4'hF;
    @(posedge clk); #1;
    rst = 1'b1;
    setExpReset();
    @(posedge clk); #1;
    driveIdle();
    rst = 1'b0;
    dmem_ack = 1'b1; dmem_rdata = 32'h7777_7777;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
